// File: rtl/rc4_pkg.sv
// Shared types and default sizing for the RC4 keystream XOR stage.
package rc4_pkg;
  localparam int KS_DEPTH_DEF = 4;
  localparam int LEN_W_DEF    = 16;

  typedef logic [7:0] byte_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_t;
endpackage

// File: rtl/rc4_ks_fifo.sv
// Keystream byte buffer: synchronous FIFO, head visible on rdata, no empty bypass.
module rc4_ks_fifo
  import rc4_pkg::*;
#(
  parameter int DEPTH = KS_DEPTH_DEF
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  push,
  input  logic  pop,
  input  logic  flush,
  input  byte_t wdata,
  output byte_t rdata,
  output logic  full,
  output logic  empty
);
  localparam int AW = $clog2(DEPTH);

  byte_t         mem [DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rdata = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)  wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop  && !empty) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full && !flush) mem[wr_ptr[AW-1:0]] <= wdata;
  end
endmodule

// File: rtl/rc4_xor_stage.sv
// XORs a message with buffered RC4 keystream; one byte per cycle, 1-cycle latency.
module rc4_xor_stage
  import rc4_pkg::*;
#(
  parameter int KS_DEPTH = KS_DEPTH_DEF,
  parameter int LEN_W    = LEN_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] msg_len,
  input  logic             ks_valid,
  input  logic [7:0]       ks_data,
  output logic             ks_ready,
  input  logic             din_valid,
  input  logic [7:0]       din_data,
  output logic             din_ready,
  output logic             dout_valid,
  output logic [7:0]       dout_data,
  input  logic             dout_ready,
  input  logic             ks_flush,
  output logic             busy,
  output logic             done,
  output logic [LEN_W-1:0] byte_cnt
);
  state_t           state;
  logic [LEN_W-1:0] remaining;
  byte_t            ks_head;
  logic             fifo_full, fifo_empty;
  logic             out_free, can_go, fire, ks_clr;

  assign ks_ready  = !fifo_full;
  assign ks_clr    = ks_flush && (state == ST_IDLE);
  assign out_free  = !dout_valid || dout_ready;
  // remaining!=0 gate keeps byte_cnt/remaining from wrapping.
  assign can_go    = (state == ST_RUN) && (remaining != '0) && !fifo_empty && out_free;
  assign din_ready = can_go;
  assign fire      = can_go && din_valid;

  rc4_ks_fifo #(.DEPTH(KS_DEPTH)) u_ks_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (ks_valid && ks_ready),
    .pop   (fire),
    .flush (ks_clr),
    .wdata (ks_data),
    .rdata (ks_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      remaining  <= '0;
      byte_cnt   <= '0;
      dout_valid <= 1'b0;
      dout_data  <= 8'h00;
      done       <= 1'b0;
      busy       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (fire) begin
        dout_data  <= din_data ^ ks_head;
        dout_valid <= 1'b1;
      end else if (dout_ready) begin
        dout_valid <= 1'b0;
      end
      case (state)
        ST_IDLE: if (start) begin
          remaining <= msg_len;
          byte_cnt  <= '0;
          busy      <= 1'b1;
          if (msg_len == '0) begin
            state <= ST_FIN;
            done  <= 1'b1;
          end else begin
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (fire) begin
            remaining <= remaining - LEN_W'(1);
            byte_cnt  <= byte_cnt + LEN_W'(1);
          end
          // Leave only once the final byte has been taken downstream.
          if (remaining == '0 && out_free) begin
            state <= ST_FIN;
            done  <= 1'b1;
          end
        end
        ST_FIN: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rc4_xor_stage.sv
// Scoreboard bench for rc4_xor_stage: keystream/expected-output queues checked on output handshakes.
module tb_rc4_xor_stage;
  import rc4_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] msg_len;
  logic        ks_valid, ks_ready, din_valid, din_ready, dout_valid, dout_ready;
  logic [7:0]  ks_data, din_data, dout_data;
  logic        ks_flush, busy, done;
  logic [15:0] byte_cnt;

  always #5 clk = ~clk;

  rc4_xor_stage #(.KS_DEPTH(4), .LEN_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .msg_len(msg_len),
    .ks_valid(ks_valid), .ks_data(ks_data), .ks_ready(ks_ready),
    .din_valid(din_valid), .din_data(din_data), .din_ready(din_ready),
    .dout_valid(dout_valid), .dout_data(dout_data), .dout_ready(dout_ready),
    .ks_flush(ks_flush), .busy(busy), .done(done), .byte_cnt(byte_cnt)
  );

  byte_t ks_q[$], exp_q[$], got_q[$];
  byte_t mon_e;
  int    n_checks = 0, n_fail = 0;

  // Handshakes are sampled on the falling edge; they complete on the next rising edge.
  always @(negedge clk) if (rst_n) begin
    if (dout_valid && dout_ready) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++; $display("FAIL sb_unexpected: got %02h, required no output", dout_data);
      end else begin
        mon_e = exp_q.pop_front();
        if (dout_data !== mon_e) begin
          n_fail++; $display("FAIL sb_dout: got %02h, required %02h", dout_data, mon_e);
        end
      end
      got_q.push_back(dout_data);
    end
    if (din_valid && din_ready) begin
      if (ks_q.size() == 0) begin
        n_checks++; n_fail++; $display("FAIL sb_ks_underflow: got fire, required empty keystream stall");
      end else exp_q.push_back(din_data ^ ks_q.pop_front());
    end
    if (ks_valid && ks_ready && !ks_flush) ks_q.push_back(ks_data);
  end

  task automatic tick(); @(posedge clk); #1; endtask

  task automatic push_ks(input byte_t b);
    ks_valid = 1'b1; ks_data = b;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (ks_ready) begin @(posedge clk); #1; ks_valid = 1'b0; return; end
    end
    n_checks++; n_fail++; $display("FAIL push_ks_timeout: got ks_ready=0, required 1");
    ks_valid = 1'b0;
  endtask

  task automatic send_din(input byte_t b);
    din_valid = 1'b1; din_data = b;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (din_ready) begin @(posedge clk); #1; din_valid = 1'b0; return; end
    end
    n_checks++; n_fail++; $display("FAIL send_din_timeout: got din_ready=0, required 1");
    din_valid = 1'b0;
  endtask

  task automatic start_msg(input logic [15:0] len);
    start = 1'b1; msg_len = len; tick(); start = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 100; i++) begin
      if (done) begin n_checks++; return; end
      tick();
    end
    n_checks++; n_fail++; $display("FAIL done_timeout: got done=0, required 1");
  endtask

  task automatic run_msg(input byte_t d[$]);
    start_msg(16'(d.size()));
    foreach (d[i]) send_din(d[i]);
    wait_done();
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 0; msg_len = 0; ks_valid = 0; ks_data = 0;
    din_valid = 0; din_data = 0; dout_ready = 1; ks_flush = 0;
    #1;
    n_checks++;
    if ({dout_valid, dout_data, done, busy, byte_cnt, ks_ready, din_ready} !== {1'b0, 8'h00, 1'b0, 1'b0, 16'h0, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL reset_state: got dv=%b dd=%02h done=%b busy=%b cnt=%0d ksr=%b dinr=%b, required 0 00 0 0 0 1 0",
        dout_valid, dout_data, done, busy, byte_cnt, ks_ready, din_ready);
    end
    tick(); tick();
    @(negedge clk) rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    got_q.delete();
    push_ks(8'hA5); push_ks(8'h3C);
    start_msg(16'd2);
    send_din(8'hFF); send_din(8'h00);
    n_checks++;
    if (dout_valid !== 1'b1 || done !== 1'b0) begin
      n_fail++; $display("FAIL basic_last_out: got dv=%b done=%b, required 1 0", dout_valid, done);
    end
    tick();
    n_checks++;
    if (done !== 1'b1 || byte_cnt !== 16'd2 || busy !== 1'b1) begin
      n_fail++; $display("FAIL basic_done: got done=%b cnt=%0d busy=%b, required 1 2 1", done, byte_cnt, busy);
    end
    tick();
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0 || byte_cnt !== 16'd2) begin
      n_fail++; $display("FAIL basic_idle: got done=%b busy=%b cnt=%0d, required 0 0 2", done, busy, byte_cnt);
    end
    n_checks++;
    if (got_q.size() != 2 || got_q[0] !== 8'h5A || got_q[1] !== 8'h3C) begin
      n_fail++; $display("FAIL basic_bytes: got %0d bytes, required 5A 3C", got_q.size());
    end
  endtask

  task automatic test_rc4_vector();
    byte_t ks[9]  = '{8'hEB, 8'h9F, 8'h77, 8'h81, 8'hB7, 8'h34, 8'hCA, 8'h72, 8'hA7};
    byte_t pt[$]  = '{8'h50, 8'h6C, 8'h61, 8'h69, 8'h6E, 8'h74, 8'h65, 8'h78, 8'h74};
    byte_t ct[9]  = '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
    got_q.delete();
    for (int i = 0; i < 4; i++) push_ks(ks[i]);
    fork
      for (int j = 4; j < 9; j++) push_ks(ks[j]);
      run_msg(pt);
    join
    n_checks++;
    if (got_q.size() != 9 || byte_cnt !== 16'd9) begin
      n_fail++; $display("FAIL vec_count: got %0d bytes cnt=%0d, required 9 9", got_q.size(), byte_cnt);
    end else begin
      for (int i = 0; i < 9; i++) begin
        n_checks++;
        if (got_q[i] !== ct[i]) begin
          n_fail++; $display("FAIL vec_byte%0d: got %02h, required %02h", i, got_q[i], ct[i]);
        end
      end
    end
  endtask

  task automatic test_zero_len();
    byte_t z[$] = '{8'h00, 8'h00};
    push_ks(8'h11); push_ks(8'h22);
    start_msg(16'd0);
    n_checks++;
    if (done !== 1'b1 || dout_valid !== 1'b0 || busy !== 1'b1 || byte_cnt !== 16'd0) begin
      n_fail++; $display("FAIL zero_done: got done=%b dv=%b busy=%b cnt=%0d, required 1 0 1 0", done, dout_valid, busy, byte_cnt);
    end
    tick();
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0 || dout_valid !== 1'b0) begin
      n_fail++; $display("FAIL zero_idle: got done=%b busy=%b dv=%b, required 0 0 0", done, busy, dout_valid);
    end
    got_q.delete();
    run_msg(z);
    n_checks++;
    if (got_q.size() != 2 || got_q[0] !== 8'h11 || got_q[1] !== 8'h22) begin
      n_fail++; $display("FAIL zero_fifo_kept: got %0d bytes, required 11 22", got_q.size());
    end
  endtask

  task automatic test_fifo_bound();
    byte_t z[$] = '{8'h00, 8'h00, 8'h00, 8'h00};
    got_q.delete();
    for (int i = 1; i <= 4; i++) push_ks(byte_t'(i));
    n_checks++;
    if (ks_ready !== 1'b0) begin n_fail++; $display("FAIL fifo_full: got ks_ready=%b, required 0", ks_ready); end
    ks_valid = 1'b1; ks_data = 8'h05;
    tick(); tick(); tick();
    n_checks++;
    if (ks_ready !== 1'b0) begin n_fail++; $display("FAIL fifo_hold: got ks_ready=%b, required 0", ks_ready); end
    start_msg(16'd1);
    send_din(8'hAA);
    n_checks++;
    if (ks_ready !== 1'b1) begin n_fail++; $display("FAIL fifo_after_pop: got ks_ready=%b, required 1", ks_ready); end
    tick();
    ks_valid = 1'b0;
    wait_done(); tick();
    run_msg(z);
    n_checks++;
    if (got_q.size() != 5 || got_q[0] !== 8'hAB || got_q[1] !== 8'h02 || got_q[4] !== 8'h05) begin
      n_fail++; $display("FAIL fifo_order: got %0d bytes, required AB 02 03 04 05", got_q.size());
    end
  endtask

  task automatic test_backpressure();
    byte_t cap;
    int    base = got_q.size();
    for (int i = 0; i < 4; i++) push_ks(byte_t'($urandom_range(0, 255)));
    start_msg(16'd4);
    fork
      for (int i = 0; i < 4; i++) send_din(byte_t'($urandom_range(0, 255)));
      begin
        for (int i = 0; i < 100 && !dout_valid; i++) @(negedge clk);
        @(posedge clk); #1;
        dout_ready = 1'b0; cap = dout_data;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          n_checks++;
          if (din_ready !== 1'b0 || dout_valid !== 1'b1 || dout_data !== cap) begin
            n_fail++; $display("FAIL bp_hold%0d: got dinr=%b dv=%b dd=%02h, required 0 1 %02h", k, din_ready, dout_valid, dout_data, cap);
          end
          @(posedge clk); #1;
        end
        dout_ready = 1'b1;
      end
    join
    wait_done(); tick();
    n_checks++;
    if (got_q.size() - base != 4 || exp_q.size() != 0 || byte_cnt !== 16'd4) begin
      n_fail++; $display("FAIL bp_count: got %0d out %0d pending cnt=%0d, required 4 0 4", got_q.size() - base, exp_q.size(), byte_cnt);
    end
  endtask

  task automatic test_reset_mid();
    byte_t d[$] = '{8'h0F, 8'hF0};
    for (int i = 0; i < 4; i++) push_ks(8'h70 + byte_t'(i));
    start_msg(16'd4);
    send_din(8'h12);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({dout_valid, dout_data, done, busy, byte_cnt, ks_ready, din_ready} !== {1'b0, 8'h00, 1'b0, 1'b0, 16'h0, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL rst_mid_state: got dv=%b dd=%02h done=%b busy=%b cnt=%0d ksr=%b dinr=%b, required 0 00 0 0 0 1 0",
        dout_valid, dout_data, done, busy, byte_cnt, ks_ready, din_ready);
    end
    ks_q.delete(); exp_q.delete();
    tick(); tick();
    @(negedge clk) rst_n = 1'b1;
    tick(); tick();
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_nodone: got done=%b busy=%b, required 0 0", done, busy);
    end
    got_q.delete();
    push_ks(8'h5A); push_ks(8'hC3);
    run_msg(d);
    n_checks++;
    if (got_q.size() != 2 || got_q[0] !== 8'h55 || got_q[1] !== 8'h33 || byte_cnt !== 16'd2) begin
      n_fail++; $display("FAIL rst_mid_rerun: got %0d bytes cnt=%0d, required 55 33 cnt 2", got_q.size(), byte_cnt);
    end
  endtask

  task automatic test_flush();
    byte_t d[$] = '{8'h01};
    push_ks(8'hE1); push_ks(8'hE2);
    ks_valid = 1'b1; ks_data = 8'h77; ks_flush = 1'b1;
    tick();
    ks_valid = 1'b0; ks_flush = 1'b0;
    ks_q.delete();
    push_ks(8'h99);
    got_q.delete();
    run_msg(d);
    n_checks++;
    if (got_q.size() != 1 || got_q[0] !== 8'h98) begin
      n_fail++; $display("FAIL flush: got %0d bytes first=%02h, required 1 byte 98", got_q.size(), got_q.size() ? got_q[0] : 8'h00);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_rc4_vector();
    test_zero_len();
    test_fifo_bound();
    test_backpressure();
    test_reset_mid();
    test_flush();
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL sb_leftover: got %0d pending, required 0", exp_q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
